// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered display data.
// Each digit slot is an all-off BLANK gap followed by a SHOW period; new data is
// swapped into the active registers only at the frame boundary so a frame never tears.
module hex_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [15:0] DATA_IN,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLANK_IN,
    input  logic        LOAD,
    output logic        LOAD_ACK,
    output logic        FRAME_DONE,
    output logic [3:0]  HEX_EN_INV,
    output logic [7:0]  HEX_LED_INV
);

    localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam bit SKIP_BLANK = (BLANK_CYCLES == 0);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             boundary;

    logic [15:0] act_data, act_data_nxt, pend_data;
    logic [3:0]  act_dp, act_dp_nxt, pend_dp;
    logic [3:0]  act_blank, act_blank_nxt, pend_blank;
    logic        pend_flag;

    logic [3:0] en_nxt;
    logic [7:0] led_nxt;
    logic [3:0] nib;

    // Hex nibble to segments A..G (A in the MSB).
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1111110;
            4'h1:    seg7 = 7'b0110000;
            4'h2:    seg7 = 7'b1101101;
            4'h3:    seg7 = 7'b1111001;
            4'h4:    seg7 = 7'b0110011;
            4'h5:    seg7 = 7'b1011011;
            4'h6:    seg7 = 7'b1011111;
            4'h7:    seg7 = 7'b1110000;
            4'h8:    seg7 = 7'b1111111;
            4'h9:    seg7 = 7'b1111011;
            4'hA:    seg7 = 7'b1110111;
            4'hB:    seg7 = 7'b0011111;
            4'hC:    seg7 = 7'b1001110;
            4'hD:    seg7 = 7'b0111101;
            4'hE:    seg7 = 7'b1001111;
            default: seg7 = 7'b1000111;
        endcase
    endfunction

    // Next-state, buffer swap and next-output decode; outputs are precomputed so they register.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt + CNT_W'(1);
        boundary      = 1'b0;
        act_data_nxt  = act_data;
        act_dp_nxt    = act_dp;
        act_blank_nxt = act_blank;
        en_nxt        = 4'b0000;
        led_nxt       = 8'h00;
        nib           = 4'h0;

        case (state)
            ST_BLANK: begin
                if (SKIP_BLANK || cnt == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == DIGIT_LAST) begin
                    idx_nxt   = idx + 2'd1;
                    cnt_nxt   = '0;
                    boundary  = (idx == 2'd3);
                    state_nxt = SKIP_BLANK ? ST_SHOW : ST_BLANK;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase

        if (boundary && pend_flag) begin
            act_data_nxt  = pend_data;
            act_dp_nxt    = pend_dp;
            act_blank_nxt = pend_blank;
        end

        nib = act_data_nxt[{idx_nxt, 2'b00} +: 4];
        if (state_nxt == ST_SHOW && !act_blank_nxt[idx_nxt]) begin
            en_nxt  = 4'b0001 << idx_nxt;
            led_nxt = {seg7(nib), act_dp_nxt[idx_nxt]};
        end
    end

    // Scan state, active buffer and registered display outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_BLANK;
            idx         <= 2'd0;
            cnt         <= '0;
            act_data    <= 16'h0000;
            act_dp      <= 4'b0000;
            act_blank   <= 4'b1111;
            HEX_EN_INV  <= 4'b0000;
            HEX_LED_INV <= 8'h00;
            FRAME_DONE  <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            act_data    <= act_data_nxt;
            act_dp      <= act_dp_nxt;
            act_blank   <= act_blank_nxt;
            HEX_EN_INV  <= en_nxt;
            HEX_LED_INV <= led_nxt;
            FRAME_DONE  <= boundary;
        end
    end

    // Pending buffer: latest LOAD wins; a LOAD in the boundary cycle stays pending.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_data  <= 16'h0000;
            pend_dp    <= 4'b0000;
            pend_blank <= 4'b0000;
            pend_flag  <= 1'b0;
            LOAD_ACK   <= 1'b0;
        end else begin
            LOAD_ACK <= LOAD;
            if (LOAD) begin
                pend_data  <= DATA_IN;
                pend_dp    <= DP_IN;
                pend_blank <= BLANK_IN;
                pend_flag  <= 1'b1;
            end else if (boundary) begin
                pend_flag <= 1'b0;
            end
        end
    end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYCLES, default 50000, clocks each digit is driven (1 ms at 50 MHz); legal range >=1.
REQ-002 Parameter BLANK_CYCLES, default 500, all-off clocks before each digit slot (anti-ghosting); legal range >=0.
REQ-003 CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 DATA_IN  in  16  four hex nibbles; [3:0]=digit0 ... [15:12]=digit3.
REQ-006 DP_IN  in  4  decimal point per digit, bit n = digit n.
REQ-007 BLANK_IN  in  4  per-digit blank, 1 = digit dark.
REQ-008 LOAD  in  1  load request, sampled every cycle while high.
REQ-009 LOAD_ACK  out  1  one-cycle pulse, load captured.
REQ-010 FRAME_DONE  out  1  one-cycle pulse at each frame boundary.
REQ-011 HEX_EN_INV  out  4  active-high digit enable, one-hot or zero; the board top inverts it.
REQ-012 HEX_LED_INV  out  8  active-high segments; [7]=A, [6]=B, [5]=C, [4]=D, [3]=E, [2]=F, [1]=G, [0]=POINT.

Function
REQ-013 FSM states: BLANK and SHOW; register digit index idx 0..3 and cycle counter.
REQ-014 BLANK: HEX_EN_INV=0, HEX_LED_INV=0, hold BLANK_CYCLES clocks, then go to SHOW; BLANK_CYCLES=0 skips BLANK entirely.
REQ-015 SHOW: HEX_EN_INV = one-hot(idx), HEX_LED_INV = decode(active nibble idx) with [0] = active DP idx; hold DIGIT_CYCLES clocks.
REQ-016 SHOW end: idx <= (idx+1) mod 4, go to BLANK; wrap 3->0 is the frame boundary.
REQ-017 Frame length SHALL be exactly 4*(BLANK_CYCLES+DIGIT_CYCLES) clocks, independent of LOAD, BLANK_IN, data.
REQ-018 Active blank bit set for idx: HEX_EN_INV and HEX_LED_INV stay 0 during that SHOW slot; slot timing unchanged.
REQ-019 Decode (A..G): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-020 Double buffer: LOAD high captures DATA_IN/DP_IN/BLANK_IN into pending regs, sets pending flag; LOAD_ACK pulses the following cycle.
REQ-021 LOAD while pending already set overwrites pending (latest wins); each captured cycle yields one ACK pulse.
REQ-022 At frame boundary with pending set: active <= pending, flag cleared; new values first shown in digit0 slot of next frame.
REQ-023 LOAD in the boundary cycle: active takes the previous pending contents (if any); the new data stays pending for the next boundary.
REQ-024 Active regs SHALL never change except at a frame boundary (no tearing mid-frame).
REQ-025 FRAME_DONE pulses for one cycle in the cycle after each boundary transition.
REQ-026 Outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-027 Counter width ceil(log2(max(DIGIT_CYCLES,BLANK_CYCLES)+1)); no overflow for legal parameters.

Reset
REQ-028 RESET_N low: immediately state=BLANK, idx=0, counter=0, all outputs 0, pending flag 0, pending/active data 0, active DP 0, active blank 4'b1111 (display dark until first load).
REQ-029 RESET_N asserted mid-operation discards any pending load with no LOAD_ACK; after release the first BLANK slot starts on the next rising edge.

Verification (DIGIT_CYCLES=4, BLANK_CYCLES=2, frame = 24 clocks)
REQ-030 Reset release, no LOAD -> HEX_EN_INV=0 and HEX_LED_INV=0 for 48 clocks; FRAME_DONE pulses 24 clocks apart.
REQ-031 LOAD 1 cycle, DATA_IN=16'h8F10, DP_IN=4'b0001, BLANK_IN=0 -> LOAD_ACK next cycle; next frame shows EN=0001/LED=8'hFD, EN=0010/LED=8'h60, EN=0100/LED=8'h8E, EN=1000/LED=8'hFE, 4 clocks each, with 2 dark clocks before each digit.
REQ-032 Two LOADs in one frame (16'h1111 then 16'h2222) -> two ACK pulses; next frame shows only 2222 (LED 8'hDA on every digit).
REQ-033 LOAD 16'h3333 exactly in a boundary cycle with nothing pending -> frame that starts shows old data; the frame after shows 3 (8'hF2).
REQ-034 Display 16'h8888 with BLANK_IN=4'b0100 -> digit2 slot has EN=0000, LED=0; other slots show 8'hFE; frame still 24 clocks.
REQ-035 RESET_N low mid-SHOW with a load pending -> outputs 0 in the same cycle; after release the display stays dark and no ACK occurs.
